pid_regfile: RTL and testbench
==============================

PID_REGFILE -- requirements
Module: pid_regfile

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of PID channels (1..16).
REQ-002 SHALL have parameter AW, default 8, meaning address width; NCH <= 2^(AW-4).
REQ-003 SHALL have port clk_in  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port write_enable  in  1  write strobe.
REQ-006 SHALL have port w_addr  in  AW  write byte address.
REQ-007 SHALL have port w_data  in  8  write byte.
REQ-008 SHALL have port read_enable  in  1  read strobe.
REQ-009 SHALL have port r_addr  in  AW  read byte address.
REQ-010 SHALL have port r_data_o  out  8  registered read byte.
REQ-011 SHALL have ports p_o, i_o, d_o, sp_o  out  NCH*16 each  active gains/setpoint; channel c at bits [16c+15:16c].
REQ-012 SHALL have ports pid_o_i, pwm_o_i  in  NCH*16 each  read-only status values, same packing.
REQ-013 SHALL have port commit_o  out  NCH  one-cycle pulse per channel when its active set updates.

Function
REQ-014 SHALL decode addresses as channel = addr[AW-1:4], reg = addr[3:1], byte = addr[0] (0 = low).
REQ-015 SHALL use reg indices P=0, I=1, D=2, SP=3 (RW, shadowed), PID_O=4, PWM_O=5 (RO), CTRL=6, 7 reserved.
REQ-016 SHALL treat channel >= NCH or reg 7 as unmapped: writes ignored, reads return 0x00.
REQ-017 SHALL, on a low-byte write to an RW reg, store the byte and its {channel,reg} tag in a per-channel staging latch and set stage-valid.
REQ-018 SHALL, on a high-byte write whose tag matches a valid stage, write {w_data, staged byte} atomically to the shadow reg and clear stage-valid.
REQ-019 SHALL, on a high-byte write without a matching valid stage, leave the shadow unchanged and set that channel's sticky ERR.
REQ-020 SHALL, on a low-byte write to a different RW reg while stage-valid, overwrite the stage (no error).
REQ-021 SHALL define CTRL low byte: bit0 COMMIT (write-1, self-clearing, reads 0), bit1 AUTO (RW), bit2 ERR (write-1-to-clear), bit3 PENDING (RO); CTRL high byte reads 0x00, writes ignored.
REQ-022 SHALL, on a COMMIT write sampled at edge k, copy all four shadows to active at edge k, clear PENDING, and drive commit_o[c] high for the following cycle only.
REQ-023 SHALL, when AUTO=1, update shadow and active together at the edge a completed 16-bit write is sampled, with commit_o[c] pulsed.
REQ-024 SHALL set PENDING when a shadow is updated with AUTO=0.
REQ-025 SHALL sample pid_o_i/pwm_o_i into RO regs every cycle.
REQ-026 SHALL, on read_enable, present the addressed byte on r_data_o one cycle later; without read_enable r_data_o holds.
REQ-027 SHALL return shadow values for RW regs.
REQ-028 SHALL, on a low-byte RO read, capture the full 16-bit RO value into a per-channel snapshot; a high-byte RO read returns the snapshot high byte (anti-tearing).
REQ-029 SHALL return the pre-write value when read and write target the same address in the same cycle.
REQ-030 SHALL give a CTRL write containing both COMMIT=1 and AUTO change priority to the commit using the old AUTO, AUTO updated the same edge.

Reset
REQ-031 SHALL, at reset, zero all shadow, active, RO, snapshot registers, r_data_o, and commit_o, and clear stage-valid, AUTO, ERR, PENDING.
REQ-032 SHALL discard any half-written stage when reset occurs mid-sequence.

Structure
REQ-033 SHALL place register indices, CTRL bit positions, and the 16-bit data width in shared package pid_regfile_pkg.
REQ-034 SHALL implement one bank per channel in sub-module pid_regfile_chan, instantiated NCH times by generate.

Verification
REQ-035 SHALL cover: write 0x34 to 0x00 then 0x12 to 0x01, commit via 0x0C=0x01 -> p_o[15:0]=0x1234 one cycle after commit edge; commit_o[0] pulses once.
REQ-036 SHALL cover: write 0xAA to 0x01 (no stage) -> P shadow unchanged, read 0x0C returns bit2=1; write 0x04 to 0x0C -> ERR=0.
REQ-037 SHALL cover: pid_o_i ch1=0x00FF, read 0x18; change input to 0x0100, read 0x19 -> 0x00 and 0xFF read back (snapshot), not 0x01.
REQ-038 SHALL cover: AUTO=1 on ch1 (0x1C=0x02), write 0x78 to 0x16 and 0x56 to 0x17 -> sp_o[31:16]=0x5678 immediately, commit_o[1] pulses, PENDING=0.
REQ-039 SHALL cover: reset asserted after low-byte write to 0x04, then 0x99 to 0x05 -> D unchanged (0x0000), ERR set.
REQ-040 SHALL cover: read of 0x2E with NCH=2 -> r_data_o=0x00; write there -> no state change.

Source files
------------

// File: rtl/pid_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pid_regfile_pkg
// Purpose : Shared definitions for the PID register file: data width,
//           register indices within a channel's 16-byte window and the
//           CTRL register bit positions.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pid_regfile_pkg;

  // Width of every gain, setpoint and status word.
  localparam int DW = 16;

  // Register index = addr[3:1] inside a channel window.
  typedef enum logic [2:0] {
    REG_P     = 3'd0,
    REG_I     = 3'd1,
    REG_D     = 3'd2,
    REG_SP    = 3'd3,
    REG_PID_O = 3'd4,
    REG_PWM_O = 3'd5,
    REG_CTRL  = 3'd6,
    REG_RSVD  = 3'd7
  } reg_idx_e;

  // CTRL low-byte bit positions.
  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_ERR     = 2;
  localparam int CTRL_PENDING = 3;

  // Registers 0..3 are the shadowed read/write words.
  function automatic logic is_rw(input logic [2:0] idx);
    return (idx < 3'd4);
  endfunction

endpackage : pid_regfile_pkg
`default_nettype wire

// File: rtl/pid_regfile_chan.sv
`default_nettype none
// ============================================================================
// Module  : pid_regfile_chan
// Purpose : One PID channel register bank: byte staging latch, four shadowed
//           RW words with active copies, CTRL (COMMIT/AUTO/ERR/PENDING),
//           sampled read-only status words and the RO anti-tearing snapshot.
// Ports   : clk, reset         - clock, synchronous active-high reset
//           wr_en/wr_reg/wr_hi/wr_data - channel-decoded byte write
//           rd_en/rd_reg/rd_hi - channel-decoded byte read (rd_en gates the
//                                snapshot capture only)
//           pid_in, pwm_in     - live status words
//           rd_data            - combinational byte for the addressed reg
//           p_act..sp_act      - active gains/setpoint
//           commit             - one-cycle pulse after the active set updates
// Revision: 1.0 - initial release
// ============================================================================
module pid_regfile_chan
  import pid_regfile_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [2:0]    wr_reg,
  input  logic          wr_hi,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [2:0]    rd_reg,
  input  logic          rd_hi,
  input  logic [DW-1:0] pid_in,
  input  logic [DW-1:0] pwm_in,
  output logic [7:0]    rd_data,
  output logic [DW-1:0] p_act,
  output logic [DW-1:0] i_act,
  output logic [DW-1:0] d_act,
  output logic [DW-1:0] sp_act,
  output logic          commit
);

  logic [DW-1:0] shadow [4];
  logic [DW-1:0] active [4];

  // Staging latch. The channel half of the {channel,reg} tag is implicit
  // because each channel owns its own latch, so only the reg index is kept.
  logic [7:0]    stage_data;
  logic [1:0]    stage_tag;
  logic          stage_valid;

  logic          auto_en;
  logic          err;
  logic          pending;

  logic [DW-1:0] pid_ro;
  logic [DW-1:0] pwm_ro;
  logic [DW-1:0] snap;

  logic          stage_hit;
  logic [DW-1:0] new_word;
  logic [DW-1:0] rd_word;
  logic [7:0]    ctrl_byte;

  assign stage_hit = stage_valid && (stage_tag == wr_reg[1:0]);
  assign new_word  = {wr_data, stage_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      stage_data  <= '0;
      stage_tag   <= '0;
      stage_valid <= 1'b0;
      auto_en     <= 1'b0;
      err         <= 1'b0;
      pending     <= 1'b0;
      pid_ro      <= '0;
      pwm_ro      <= '0;
      snap        <= '0;
      commit      <= 1'b0;
    end else begin
      commit <= 1'b0;
      pid_ro <= pid_in;
      pwm_ro <= pwm_in;

      // A low-byte RO read freezes the whole word so the following high-byte
      // read cannot tear against a status update in between.
      if (rd_en && !rd_hi && (rd_reg == REG_PID_O)) begin
        snap <= pid_ro;
      end else if (rd_en && !rd_hi && (rd_reg == REG_PWM_O)) begin
        snap <= pwm_ro;
      end

      if (wr_en) begin
        if (is_rw(wr_reg)) begin
          if (!wr_hi) begin
            // A new low byte always replaces whatever was staged.
            stage_data  <= wr_data;
            stage_tag   <= wr_reg[1:0];
            stage_valid <= 1'b1;
          end else if (stage_hit) begin
            shadow[wr_reg[1:0]] <= new_word;
            stage_valid         <= 1'b0;
            if (auto_en) begin
              active[wr_reg[1:0]] <= new_word;
              commit              <= 1'b1;
            end else begin
              pending <= 1'b1;
            end
          end else begin
            // Orphan high byte: shadow untouched, flag it.
            err <= 1'b1;
          end
        end else if ((wr_reg == REG_CTRL) && !wr_hi) begin
          // AUTO takes its new value on this edge; the commit below is
          // independent of AUTO, so a combined write commits first in effect.
          auto_en <= wr_data[CTRL_AUTO];
          if (wr_data[CTRL_ERR]) begin
            err <= 1'b0;
          end
          if (wr_data[CTRL_COMMIT]) begin
            for (int k = 0; k < 4; k++) begin
              active[k] <= shadow[k];
            end
            pending <= 1'b0;
            commit  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ctrl_byte               = '0;
    ctrl_byte[CTRL_AUTO]    = auto_en;
    ctrl_byte[CTRL_ERR]     = err;
    ctrl_byte[CTRL_PENDING] = pending;
  end

  always_comb begin
    rd_word = '0;
    case (rd_reg)
      REG_P, REG_I, REG_D, REG_SP: rd_word = shadow[rd_reg[1:0]];
      REG_PID_O:                   rd_word = rd_hi ? snap : pid_ro;
      REG_PWM_O:                   rd_word = rd_hi ? snap : pwm_ro;
      REG_CTRL:                    rd_word = {8'h00, ctrl_byte};
      default:                     rd_word = '0;
    endcase
    rd_data = rd_hi ? rd_word[15:8] : rd_word[7:0];
  end

  assign p_act  = active[0];
  assign i_act  = active[1];
  assign d_act  = active[2];
  assign sp_act = active[3];

endmodule : pid_regfile_chan
`default_nettype wire

// File: rtl/pid_regfile.sv
`default_nettype none
// ============================================================================
// Module  : pid_regfile
// Purpose : Byte-addressed register file for NCH PID channels. Each channel
//           occupies a 16-byte window (channel = addr[AW-1:4]); the top
//           decodes the channel, hosts one bank per channel and registers
//           the read byte.
// Ports   : clk_in, reset                  - clock, sync active-high reset
//           write_enable, w_addr, w_data   - byte write port
//           read_enable, r_addr, r_data_o  - byte read port (1-cycle latency)
//           p_o, i_o, d_o, sp_o            - active words, 16 bits/channel
//           pid_o_i, pwm_o_i               - status inputs, 16 bits/channel
//           commit_o                       - per-channel commit pulse
// Revision: 1.0 - initial release
// ============================================================================
module pid_regfile
  import pid_regfile_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 8
)
(
  input  logic               clk_in,
  input  logic               reset,
  input  logic               write_enable,
  input  logic [AW-1:0]      w_addr,
  input  logic [7:0]         w_data,
  input  logic               read_enable,
  input  logic [AW-1:0]      r_addr,
  output logic [7:0]         r_data_o,
  output logic [NCH*DW-1:0]  p_o,
  output logic [NCH*DW-1:0]  i_o,
  output logic [NCH*DW-1:0]  d_o,
  output logic [NCH*DW-1:0]  sp_o,
  input  logic [NCH*DW-1:0]  pid_o_i,
  input  logic [NCH*DW-1:0]  pwm_o_i,
  output logic [NCH-1:0]     commit_o
);

  localparam int CH_W = AW - 4;

  logic [CH_W-1:0] w_ch;
  logic [CH_W-1:0] r_ch;
  logic [7:0]      chan_rd [NCH];
  logic [7:0]      rd_mux;

  assign w_ch = w_addr[AW-1:4];
  assign r_ch = r_addr[AW-1:4];

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chan
      logic wr_sel;
      logic rd_sel;

      // Channels at or above NCH never match, so their writes fall away.
      assign wr_sel = write_enable && (w_ch == CH_W'(g));
      assign rd_sel = read_enable  && (r_ch == CH_W'(g));

      pid_regfile_chan u_chan (
        .clk     (clk_in),
        .reset   (reset),
        .wr_en   (wr_sel),
        .wr_reg  (w_addr[3:1]),
        .wr_hi   (w_addr[0]),
        .wr_data (w_data),
        .rd_en   (rd_sel),
        .rd_reg  (r_addr[3:1]),
        .rd_hi   (r_addr[0]),
        .pid_in  (pid_o_i[g*DW +: DW]),
        .pwm_in  (pwm_o_i[g*DW +: DW]),
        .rd_data (chan_rd[g]),
        .p_act   (p_o[g*DW +: DW]),
        .i_act   (i_o[g*DW +: DW]),
        .d_act   (d_o[g*DW +: DW]),
        .sp_act  (sp_o[g*DW +: DW]),
        .commit  (commit_o[g])
      );
    end
  endgenerate

  // Unmapped channels leave the mux at zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_ch == CH_W'(c)) begin
        rd_mux = chan_rd[c];
      end
    end
  end

  // Read data is taken from pre-edge state, so a same-cycle write to the
  // same address is not visible until the next read.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_data_o <= '0;
    end else if (read_enable) begin
      r_data_o <= rd_mux;
    end
  end

endmodule : pid_regfile
`default_nettype wire

// File: tb/tb_pid_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_pid_regfile
// Purpose : Self-checking bench for pid_regfile (NCH=2, AW=8). Read
//           expectations are queued when a read is issued and compared when
//           the registered byte appears.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pid_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [7:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        read_enable = 1'b0;
  logic [7:0]  r_addr = '0;
  logic [7:0]  r_data_o;
  logic [31:0] p_o, i_o, d_o, sp_o;
  logic [31:0] pid_o_i = '0;
  logic [31:0] pwm_o_i = '0;
  logic [1:0]  commit_o;

  int          total = 0;
  int          passed = 0;
  logic [7:0]  sb [$];
  logic [7:0]  exp8;

  pid_regfile #(.NCH(2), .AW(8)) dut (
    .clk_in       (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .read_enable  (read_enable),
    .r_addr       (r_addr),
    .r_data_o     (r_data_o),
    .p_o          (p_o),
    .i_o          (i_o),
    .d_o          (d_o),
    .sp_o         (sp_o),
    .pid_o_i      (pid_o_i),
    .pwm_o_i      (pwm_o_i),
    .commit_o     (commit_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // Both stimulus tasks start and end on a falling edge; the rising edge in
  // between samples the strobe.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    write_enable = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    read_enable = 1'b1; r_addr = a; sb.push_back(e);
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({p_o, i_o, d_o, sp_o} !== '0) $display("FAIL reset_outputs: got %h expected 0", {p_o, i_o, d_o, sp_o}); else passed++;
    total++; if (commit_o !== 2'b00) $display("FAIL reset_commit: got %b expected 00", commit_o); else passed++;
    total++; if (r_data_o !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", r_data_o); else passed++;
    reset = 1'b0;
    rd(8'h0C, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL reset_ctrl0: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h1C, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL reset_ctrl1: got %h expected %h", r_data_o, exp8); else passed++;
  endtask

  task automatic test_commit();
    wr(8'h00, 8'h34);
    wr(8'h01, 8'h12);
    total++; if (p_o[15:0] !== 16'h0000) $display("FAIL precommit_p: got %h expected 0000", p_o[15:0]); else passed++;
    rd(8'h0C, 8'h08);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL pending_set: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h00, 8'h34);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL shadow_p_lo: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h01, 8'h12);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL shadow_p_hi: got %h expected %h", r_data_o, exp8); else passed++;
    wr(8'h0C, 8'h01);
    total++; if (p_o[15:0] !== 16'h1234) $display("FAIL commit_p: got %h expected 1234", p_o[15:0]); else passed++;
    total++; if (commit_o !== 2'b01) $display("FAIL commit_pulse: got %b expected 01", commit_o); else passed++;
    @(negedge clk);
    total++; if (commit_o !== 2'b00) $display("FAIL commit_single: got %b expected 00", commit_o); else passed++;
    rd(8'h0C, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL pending_clear: got %h expected %h", r_data_o, exp8); else passed++;
  endtask

  task automatic test_err();
    wr(8'h01, 8'hAA);
    rd(8'h01, 8'h12);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL orphan_shadow: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h0C, 8'h04);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL err_set: got %h expected %h", r_data_o, exp8); else passed++;
    wr(8'h0C, 8'h04);
    rd(8'h0C, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL err_clear: got %h expected %h", r_data_o, exp8); else passed++;
    // Stage overwrite: I low, then D low, so I high is orphaned and D high lands.
    wr(8'h02, 8'h11);
    wr(8'h04, 8'h22);
    wr(8'h03, 8'h33);
    wr(8'h05, 8'h44);
    rd(8'h03, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL overwrite_i: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h04, 8'h22);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL overwrite_d_lo: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h05, 8'h44);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL overwrite_d_hi: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h0C, 8'h0C);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL err_pending: got %h expected %h", r_data_o, exp8); else passed++;
    wr(8'h0C, 8'h05);
    total++; if (d_o[15:0] !== 16'h4422) $display("FAIL commit_d: got %h expected 4422", d_o[15:0]); else passed++;
    total++; if (i_o[15:0] !== 16'h0000) $display("FAIL commit_i: got %h expected 0000", i_o[15:0]); else passed++;
    rd(8'h0C, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL commit_err_clear: got %h expected %h", r_data_o, exp8); else passed++;
  endtask

  task automatic test_snapshot();
    pid_o_i[31:16] = 16'h00FF;
    pwm_o_i[15:0]  = 16'hBEEF;
    repeat (2) @(negedge clk);
    rd(8'h18, 8'hFF);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL snap_lo: got %h expected %h", r_data_o, exp8); else passed++;
    pid_o_i[31:16] = 16'h0100;
    repeat (2) @(negedge clk);
    rd(8'h19, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL snap_hi: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h18, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL snap_lo_new: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h19, 8'h01);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL snap_hi_new: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h0A, 8'hEF);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL pwm_lo: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h0B, 8'hBE);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL pwm_hi: got %h expected %h", r_data_o, exp8); else passed++;
    repeat (2) @(negedge clk);
    total++; if (r_data_o !== 8'hBE) $display("FAIL rdata_hold: got %h expected be", r_data_o); else passed++;
  endtask

  task automatic test_auto();
    wr(8'h1C, 8'h02);
    rd(8'h1C, 8'h02);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL auto_set: got %h expected %h", r_data_o, exp8); else passed++;
    wr(8'h16, 8'h78);
    wr(8'h17, 8'h56);
    total++; if (sp_o[31:16] !== 16'h5678) $display("FAIL auto_sp: got %h expected 5678", sp_o[31:16]); else passed++;
    total++; if (commit_o !== 2'b10) $display("FAIL auto_pulse: got %b expected 10", commit_o); else passed++;
    total++; if (sp_o[15:0] !== 16'h0000) $display("FAIL auto_other_ch: got %h expected 0000", sp_o[15:0]); else passed++;
    rd(8'h1C, 8'h02);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL auto_no_pending: got %h expected %h", r_data_o, exp8); else passed++;
    total++; if (commit_o !== 2'b00) $display("FAIL auto_single: got %b expected 00", commit_o); else passed++;
    // Commit together with AUTO going 1 -> 0, then 0 -> 1.
    wr(8'h1C, 8'h01);
    total++; if (commit_o !== 2'b10) $display("FAIL combo_commit: got %b expected 10", commit_o); else passed++;
    wr(8'h10, 8'h11);
    wr(8'h11, 8'h22);
    total++; if (p_o[31:16] !== 16'h0000) $display("FAIL combo_manual: got %h expected 0000", p_o[31:16]); else passed++;
    rd(8'h1C, 8'h08);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL combo_pending: got %h expected %h", r_data_o, exp8); else passed++;
    wr(8'h1C, 8'h03);
    total++; if (p_o[31:16] !== 16'h2211) $display("FAIL combo_commit2: got %h expected 2211", p_o[31:16]); else passed++;
    rd(8'h1C, 8'h02);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL combo_ctrl: got %h expected %h", r_data_o, exp8); else passed++;
  endtask

  task automatic test_back_to_back();
    wr(8'h00, 8'h77);
    // Same-cycle write and read of P high: read sees the old byte.
    write_enable = 1'b1; w_addr = 8'h01; w_data = 8'h66;
    read_enable  = 1'b1; r_addr = 8'h01; sb.push_back(8'h12);
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b0;
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL rw_same_addr: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h01, 8'h66);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL rw_after: got %h expected %h", r_data_o, exp8); else passed++;
    write_enable = 1'b1; w_addr = 8'h0C; w_data = 8'h01;
    read_enable  = 1'b1; r_addr = 8'h0C; sb.push_back(8'h08);
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b0;
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL rw_ctrl_same: got %h expected %h", r_data_o, exp8); else passed++;
    total++; if (p_o[15:0] !== 16'h6677) $display("FAIL rw_commit_p: got %h expected 6677", p_o[15:0]); else passed++;
    rd(8'h0C, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL rw_ctrl_after: got %h expected %h", r_data_o, exp8); else passed++;
  endtask

  task automatic test_unmapped();
    rd(8'h2E, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL unmapped_rd: got %h expected %h", r_data_o, exp8); else passed++;
    wr(8'h2E, 8'hFF);
    wr(8'h20, 8'h01);
    wr(8'h21, 8'h02);
    wr(8'h0E, 8'h01);
    wr(8'h0F, 8'hFF);
    wr(8'h0D, 8'hFF);
    total++; if (commit_o !== 2'b00) $display("FAIL unmapped_commit: got %b expected 00", commit_o); else passed++;
    total++; if (p_o !== 32'h2211_6677) $display("FAIL unmapped_p: got %h expected 22116677", p_o); else passed++;
    rd(8'h0E, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL reserved_rd: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h0D, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL ctrl_hi_rd: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h0C, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL unmapped_ctrl0: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h00, 8'h77);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL unmapped_alias: got %h expected %h", r_data_o, exp8); else passed++;
  endtask

  task automatic test_reset_mid();
    wr(8'h04, 8'h55);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr(8'h05, 8'h99);
    total++; if (d_o !== 32'h0) $display("FAIL midreset_d_active: got %h expected 0", d_o); else passed++;
    total++; if (p_o !== 32'h0) $display("FAIL midreset_p_active: got %h expected 0", p_o); else passed++;
    rd(8'h04, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL midreset_d_lo: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h05, 8'h00);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL midreset_d_hi: got %h expected %h", r_data_o, exp8); else passed++;
    rd(8'h0C, 8'h04);
    exp8 = sb.pop_front(); total++; if (r_data_o !== exp8) $display("FAIL midreset_err: got %h expected %h", r_data_o, exp8); else passed++;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_err();
    test_snapshot();
    test_auto();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_pid_regfile
`default_nettype wire
